// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates the 2048x32 program/data SRAM between the CPU
// fetch/load port and the debug unit, and owns the halt handshake.
// Debug writes are granted only once CPU traffic has been drained and halted.
// Read data returns with a fixed one-cycle latency.
// Optional build macro: MEM_ACCESS_PERF_EN adds the cpu_acc_cnt/dbg_acc_cnt
// access counters. Without it the counter ports do not exist.
module mem_access_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              halt_req,
  output logic              halt_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_n,
  output logic              mem_idle,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ACCESS_PERF_EN
  ,
  output logic [31:0]       cpu_acc_cnt,
  output logic [31:0]       dbg_acc_cnt
`endif
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED, RESUME} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic              rd_outstanding;

  // A read granted last cycle is still completing while either rvalid is high.
  assign rd_outstanding = cpu_rvalid | dbg_rvalid;

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Next-state decode and combinational grants (at most one grant per cycle).
  // NOTE: every output of this block is defaulted first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    unique case (state)
      RUN: begin
        // CPU has priority; debug only gets background reads here.
        if (cpu_req)                cpu_gnt = 1'b1;
        else if (dbg_req && !dbg_we) dbg_gnt = 1'b1;
        if (halt_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Completes even if halt_req was dropped; HALTED then exits next cycle.
        if (!rd_outstanding) state_nxt = HALTED;
      end
      HALTED: begin
        if (!halt_req) state_nxt = RESUME;
        else if (dbg_req) dbg_gnt = 1'b1;
      end
      RESUME: begin
        state_nxt = halt_req ? DRAIN : RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // SRAM-side drive, derived from whichever requester holds the grant.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr_n  = 1'b1;
    if (cpu_gnt) begin
      mem_addr = cpu_addr;
    end else if (dbg_gnt) begin
      mem_addr = dbg_addr;
      if (dbg_we) begin
        mem_wdata = dbg_wdata;
        mem_wr_n  = 1'b0;
      end
    end
  end

  assign mem_idle = !(cpu_gnt || dbg_gnt);

  // Read-valid pulses and the registered halt acknowledge.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      halt_ack   <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_gnt;
      dbg_rvalid <= dbg_gnt && !dbg_we;
      halt_ack   <= (state_nxt == HALTED);
    end
  end

  // Capture returned data so rdata holds its last value between reads.
  // NOTE: pure datapath holding registers carry no reset; their contents are
  // only meaningful once the matching rvalid has pulsed.
  always_ff @(posedge Clk) begin
    if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
    if (dbg_rvalid) dbg_rdata_q <= mem_rdata;
  end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rdata_q;

`ifdef MEM_ACCESS_PERF_EN
  logic cnt_clr;

  // A debug write to the top word clears both counters; the write still lands.
  assign cnt_clr = dbg_gnt && dbg_we && (dbg_addr == {ADDR_W{1'b1}});

  // Wrap-around access counters, one per requester.
  always_ff @(posedge Clk) begin
    if (!Rst_n || cnt_clr) begin
      cpu_acc_cnt <= '0;
      dbg_acc_cnt <= '0;
    end else begin
      if (cpu_gnt) cpu_acc_cnt <= cpu_acc_cnt + 32'd1;
      if (dbg_gnt) dbg_acc_cnt <= dbg_acc_cnt + 32'd1;
    end
  end
`endif

endmodule
